// File: rtl/dmemory_burst.sv
// dmemory_burst: clocked data memory with programmable latency, critical-word-first wrapped bursts and byte-enabled writes
module dmemory_burst #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 24,
  parameter int BURST_LEN = 64,
  parameter int LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_burst,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  rlast,
  output logic                  busy
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int LW = $clog2(LATENCY + 1);
  localparam int SW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RD, WR} state_t;
  state_t state, state_nxt;
  logic we_q, burst_q, wfire;
  logic [ADDR_W-1:0] addr_q, wr_addr, rd_addr;
  logic [BW-1:0] beat, beat_nxt, last, rd_beat;
  logic [LW-1:0] lat;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign req_ready = state == IDLE;
  assign wready    = state == WR;
  assign busy      = state != IDLE;
  assign wfire     = wready & wvalid;
  assign last      = burst_q ? BW'(BURST_LEN - 1) : '0;
  // rdata is registered, so the read side fetches the beat it will present next cycle
  assign rd_beat   = state == WAIT ? '0 : beat + BW'(1);
  assign wr_addr   = {addr_q[ADDR_W-1:BW], addr_q[BW-1:0] + beat};
  assign rd_addr   = {addr_q[ADDR_W-1:BW], addr_q[BW-1:0] + rd_beat};
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    unique case (state)
      IDLE: begin
        beat_nxt  = '0;
        state_nxt = req_valid ? WAIT : IDLE;
      end
      WAIT: state_nxt = lat != '0 ? WAIT : (we_q ? WR : RD);
      RD: begin
        state_nxt = beat == last ? IDLE : RD;
        beat_nxt  = beat == last ? beat : beat + BW'(1);
      end
      WR: begin
        state_nxt = wfire && beat == last ? IDLE : WR;
        beat_nxt  = wfire && beat != last ? beat + BW'(1) : beat;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      lat     <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      addr_q  <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
    end else begin
      state  <= state_nxt;
      beat   <= beat_nxt;
      lat    <= state == IDLE ? LW'(LATENCY - 1) : (lat != '0 ? lat - LW'(1) : lat);
      rvalid <= state_nxt == RD;
      rlast  <= state_nxt == RD && rd_beat == last;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        burst_q <= req_burst;
        addr_q  <= req_addr;
      end
      if (state_nxt == RD) rdata <= mem[rd_addr];
    end
  end
  // storage is deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (wfire)
      for (int i = 0; i < SW; i++)
        if (wstrb[i]) mem[wr_addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dmemory_burst.sv
// tb_dmemory_burst: randomized and directed scoreboard bench for dmemory_burst
module tb_dmemory_burst;
  localparam int DW = 32, AW = 12, BL = 64, LAT = 4;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_we = 0, req_burst = 0, wvalid = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic req_ready, wready, rvalid, rlast, busy;
  logic [DW-1:0] rdata;

  dmemory_burst #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_burst(req_burst), .req_addr(req_addr), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0, beats_seen = 0;
  logic [DW-1:0] ref_mem [2**AW];
  typedef struct {logic [DW-1:0] d; logic l; int t;} exp_t;
  exp_t sbq[$];
  exp_t e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // wrapped beat address: stays inside the aligned line of the first beat
  function automatic logic [AW-1:0] baddr(input logic [AW-1:0] a, input int k);
    return AW'((int'(a) & ~(BL - 1)) | ((int'(a) + k) % BL));
  endfunction

  always @(negedge clk) begin
    if (!rst && rvalid) begin
      beats_seen++;
      if (sbq.size() == 0) chk("unexpected_rvalid", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("rdata", rdata, e.d);
        chk("rlast", rlast, e.l);
        chk("beat_cycle", cyc, e.t);
        chk("busy_ready_during_read", {busy, req_ready}, 2'b10);
      end
    end
  end

  task automatic issue(input logic we, input logic burst, input logic [AW-1:0] a, output int acc);
    int n = 0;
    while (!req_ready && n < 2000) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1; req_we = we; req_burst = burst; req_addr = a;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 0;
    chk("busy_after_accept", {busy, req_ready}, 2'b10);
    if (!we)
      for (int k = 0; k < (burst ? BL : 1); k++)
        sbq.push_back('{ref_mem[baddr(a, k)], k == (burst ? BL - 1 : 0), acc + LAT + k});
  endtask

  task automatic rd(input logic burst, input logic [AW-1:0] a);
    int acc;
    issue(0, burst, a, acc);
  endtask

  // mode: 0 random data+strobe with random gaps, 1 data=address, 2 fixed, 3 random data full strobe
  task automatic wr(input logic burst, input logic [AW-1:0] a, input int mode,
                    input logic [DW-1:0] fd, input logic [3:0] fs, input int stall_at);
    int acc, n;
    logic [DW-1:0] d;
    logic [3:0] s;
    logic [AW-1:0] ba;
    issue(1, burst, a, acc);
    for (int k = 0; k < (burst ? BL : 1); k++) begin
      ba = baddr(a, k);
      d = mode == 1 ? DW'(ba) : mode == 2 ? fd : DW'($urandom);
      s = mode == 0 ? 4'($urandom) : mode == 2 ? fs : 4'hF;
      if (k == stall_at || (mode == 0 && k > 0 && $urandom_range(3) == 0)) begin
        wvalid = 0;
        repeat (k == stall_at ? 5 : $urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      wvalid = 1; wdata = d; wstrb = s; n = 0;
      while (!wready && n < 100) begin @(posedge clk); #1; n++; end
      chk("wready_seen", wready, 1);
      if (k == 0) chk("first_wready_cycle", cyc, acc + LAT);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[ba][8*i +: 8] = d[8*i +: 8];
    end
    wvalid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 500) begin @(posedge clk); #1; n++; end
    chk("scoreboard_drained", sbq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_ready"}, req_ready, 1);
    chk({name, "_rvalid_rlast"}, {rvalid, rlast}, 2'b00);
    chk({name, "_wready_busy"}, {wready, busy}, 2'b00);
    chk({name, "_rdata"}, rdata, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int target, n, c0, acc;
    #2 rst = 1;
    #1 check_reset_outputs("reset_initial");
    repeat (2) @(posedge clk);
    #3 rst = 0;
    @(posedge clk); #1;
    for (int l = 0; l < 16; l++) wr(1, AW'(l * BL), 3, '0, '0, -1);
    // single write then read
    wr(0, 12'h010, 2, 32'hDEADBEEF, 4'hF, -1);
    rd(0, 12'h010);
    // byte strobes
    wr(0, 12'h020, 2, 32'h11223344, 4'hF, -1);
    wr(0, 12'h020, 2, 32'hAABBCCDD, 4'b0101, -1);
    rd(0, 12'h020);
    // wrapped burst over a line holding its own addresses
    wr(1, 12'h040, 1, '0, '0, -1);
    rd(1, 12'h07E);
    // burst write with a stall after beat 10
    wr(1, 12'h080, 3, '0, '0, 11);
    rd(1, 12'h080);
    drain();
    // reset in the middle of a burst read
    target = beats_seen + 20;
    rd(1, 12'h105);
    n = 0;
    while (beats_seen < target && n < 200) begin @(posedge clk); #1; n++; end
    chk("midburst_reached", beats_seen >= target, 1);
    #2 rst = 1;
    #1 check_reset_outputs("reset_midburst");
    sbq.delete();
    @(posedge clk);
    #3 rst = 0;
    c0 = cyc;
    issue(0, 0, 12'h107, acc);
    chk("post_reset_accept_edge", acc, c0 + 1);
    rd(1, 12'h100);
    drain();
    // randomized traffic over the preloaded region
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(1)) wr($urandom_range(3) == 0, AW'($urandom_range(0, 12'h3FF)), 0, '0, '0, -1);
      else rd($urandom_range(3) == 0, AW'($urandom_range(0, 12'h3FF)));
    end
    drain();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
